uart_tx_param: RTL
==================

Name: uart_tx_param

Overview:
Parametrised UART transmitter, successor to the fixed-format TX block.
- Adds a TX FIFO with a valid/ready write port.
- Frame format (5–8 data bits, parity none/even/odd/mark, 1 or 2 stop bits) is selected at runtime.
- Baud rate comes from a runtime clock divisor instead of two hardwired rates.
- Sits between the bus/register interface and the serial TX pin; frames go out back-to-back while the FIFO holds data.

Parameters:
FIFO_DEPTH, 8, number of FIFO words; power of two, minimum 2.
DIV_WIDTH, 16, width of the baud divisor input.

Ports:
clock  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
i_Data  in  8  write data; bits above the configured length are ignored.
i_Valid  in  1  write request.
o_Ready  out  1  FIFO not full; a write is accepted on an edge where i_Valid && o_Ready.
i_DataBits  in  2  data length: 00=5, 01=6, 10=7, 11=8.
i_ParityMode  in  2  parity: 00=none, 01=even, 10=odd, 11=mark (constant 1).
i_StopBits  in  1  0=one stop bit, 1=two stop bits.
i_Divisor  in  DIV_WIDTH  clocks per bit; 0 is treated as 1.
o_DataOut  out  1  serial line; idles high.
o_Busy  out  1  a frame is in progress.
o_Done  out  1  one-cycle pulse on the last clock of each frame's final stop bit.
o_Level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset: o_DataOut=1, o_Busy=0, o_Done=0, o_Level=0, o_Ready=1. The FIFO is emptied and the FSM goes to IDLE. Reset mid-frame aborts the frame; the line is high after the reset edge.
- FIFO:
  - Push on i_Valid && o_Ready. A push while full is impossible, because o_Ready=0 when full, even if a pop happens on the same edge.
  - Pop is issued only by the FSM, in IDLE with the FIFO not empty.
  - Simultaneous push and pop leaves o_Level unchanged.
  - o_Ready and o_Level are registered-state derived and update on the same edge as the push/pop.
- Config latch: i_DataBits, i_ParityMode, i_StopBits and i_Divisor are captured at the pop edge and held for the whole frame. Changes mid-frame do not affect the current frame.
- FSM states and transitions:
  - IDLE: o_DataOut=1, o_Busy=0. If the FIFO is non-empty: pop, load the shift register, drive o_DataOut=0, set o_Busy=1, go to START.
  - START: 1 bit period low, then go to DATA.
  - DATA: N bits, LSB first, each one bit period. After the last bit, go to PARITY if mode≠none, otherwise go to STOP.
  - PARITY:
    - Even parity bit = XOR of the N data bits.
    - Odd parity bit = inverted XOR of the N data bits.
    - Mark parity bit = 1.
  - STOP: line high for 1 or 2 bit periods.
    - On the final clock of the stop period, o_Done=1.
    - The next edge returns to IDLE with o_Busy=0; if the FIFO is non-empty on that edge, IDLE pops on the following edge.
- Inter-frame gap: between back-to-back frames, exactly one idle-high clock separates the last stop period from the next start bit.
- Bit timing: a down-counter is loaded with divisor−1 at every bit boundary. One bit period = max(i_Divisor,1) clocks exactly; there is no drift accumulation.
- Latency: for a write accepted at edge E into an empty FIFO with the FSM idle, the pop occurs at E+1 and o_DataOut goes low after E+1.
- Frame length in clocks: D × (1 + N + P + S), where P ∈ {0,1} and S ∈ {1,2}.
- o_DataOut is driven from a register; it is glitch-free with no combinational path from the inputs.

Test Plan:
1. Divisor=4, 8N1, write 0xA5 while idle.
   - o_DataOut after E+1: low for 4 clocks, then 1,0,1,0,0,1,0,1 at 4 clocks each, then high for 4 clocks.
   - o_Busy is high for 40 clocks; o_Done pulses once at clock 40.
2. Divisor=2, 7 data bits, even parity, 2 stop bits, write 0x41.
   - Data bits 1,0,0,0,0,0,1; parity bit 0; stop high for 4 clocks.
   - Frame length 22 clocks.
3. Divisor=1, 5 data bits, odd parity, write 0xFF.
   - Data bits 1,1,1,1,1; parity 0; 1 stop bit; frame length 8 clocks.
   - Repeat with i_Divisor=0 → identical waveform.
4. Idle, divisor=3, i_Valid held high for 10 consecutive cycles starting at E.
   - Words 0–8 are accepted; o_Level=8 and o_Ready=0 after E+8; the 10th write is rejected.
   - All 9 frames go out back-to-back, each separated by exactly one idle clock.
   - o_Level reaches 0 at the pop for word 8.
5. Mid-frame config change: during DATA of a 0x3C 8N1 frame, switch to 6E1 with divisor 8.
   - The current frame completes unchanged.
   - The next queued word uses the new format.
6. Reset asserted for 1 cycle during the PARITY bit with 3 words queued.
   - Next cycle: o_DataOut=1, o_Busy=0, o_Level=0, o_Ready=1.
   - No further frames are sent until a new write.

Source files
------------

// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter with runtime frame format and baud divisor.
module uart_tx_param #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [7:0]                         i_Data,
  input  logic                               i_Valid,
  output logic                               o_Ready,
  input  logic [1:0]                         i_DataBits,
  input  logic [1:0]                         i_ParityMode,
  input  logic                               i_StopBits,
  input  logic [DIV_WIDTH-1:0]               i_Divisor,
  output logic                               o_DataOut,
  output logic                               o_Busy,
  output logic                               o_Done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_Level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] level;
  logic push, pop;
  logic [7:0] head, mask;
  logic [DIV_WIDTH-1:0] div, div_r, cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic [1:0] nbits_r, par_r;
  logic two_stop, stop_left, par_bit, data_out;
  assign o_Ready = level != LW'(FIFO_DEPTH);
  assign push = i_Valid && o_Ready;
  assign pop = state == IDLE && level != '0;
  assign head = mem[rd_ptr];
  assign mask = 8'hFF >> (2'd3 - i_DataBits);
  assign div = i_Divisor == '0 ? DIV_WIDTH'(1) : i_Divisor;
  assign o_DataOut = data_out;
  assign o_Busy = state != IDLE;
  assign o_Done = state == STOP && cnt == '0 && !stop_left;
  assign o_Level = level;
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= i_Data;
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) level <= level + 1'b1;
      else if (!push && pop) level <= level - 1'b1;
    end
  end
  // Format and divisor are frozen at the pop so mid-frame config changes only affect later frames.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      data_out <= 1'b1;
      cnt <= '0;
      div_r <= DIV_WIDTH'(1);
      bit_idx <= '0;
      shreg <= '0;
      nbits_r <= '0;
      par_r <= '0;
      two_stop <= 1'b0;
      stop_left <= 1'b0;
      par_bit <= 1'b0;
    end else if (state == IDLE) begin
      if (pop) begin
        state <= START;
        data_out <= 1'b0;
        shreg <= head;
        div_r <= div;
        cnt <= div - 1'b1;
        nbits_r <= i_DataBits;
        par_r <= i_ParityMode;
        two_stop <= i_StopBits;
        par_bit <= i_ParityMode == 2'd2 ? ~^(head & mask) : (i_ParityMode == 2'd3 || ^(head & mask));
      end
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      cnt <= div_r - 1'b1;
      case (state)
        START: begin
          state <= DATA;
          data_out <= shreg[0];
          shreg <= shreg >> 1;
          bit_idx <= '0;
        end
        DATA: begin
          if (bit_idx == {1'b0, nbits_r} + 3'd4) begin
            state <= par_r != 2'd0 ? PARITY : STOP;
            data_out <= par_r != 2'd0 ? par_bit : 1'b1;
            stop_left <= two_stop;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            data_out <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        PARITY: begin
          state <= STOP;
          data_out <= 1'b1;
          stop_left <= two_stop;
        end
        STOP: begin
          if (stop_left) stop_left <= 1'b0;
          else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
